// File: rtl/multi_level_priority_arbiter_pkg.sv
// Shared definitions for the multi-level priority arbiter: controller state
// encodings used by the top-level FSM.
package multi_level_priority_arbiter_pkg;

    // IDLE: output register empty, ready to grant.
    // HOLD: output register valid, waiting for the downstream consume.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/multi_level_priority_arbiter_rr_mask_picker.sv
// Round-robin picker: returns the first set bit of the candidate mask,
// searching upward from last_grant+1 and wrapping around to way 0.
module rr_mask_picker #(
    parameter int NUM_REQUEST = 4,
    parameter int WAY_WIDTH   = 2
) (
    input  logic [NUM_REQUEST-1:0] candidate_mask,
    input  logic [WAY_WIDTH-1:0]   last_grant,
    output logic [NUM_REQUEST-1:0] winner_onehot
);

    logic                 found;
    logic [WAY_WIDTH-1:0] idx;

    // Scan candidates in rotated order and mark the first one found.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        winner_onehot = '0;
        found         = 1'b0;
        idx           = '0;
        for (int k = 1; k <= NUM_REQUEST; k++) begin
            idx = WAY_WIDTH'((int'(last_grant) + k) % NUM_REQUEST);
            if (!found && candidate_mask[idx]) begin
                winner_onehot[idx] = 1'b1;
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_level_priority_arbiter.sv
// Multi-level priority arbiter with starvation promotion and a single-entry
// output register. The highest effective priority among valid ways wins; ties
// rotate round-robin. A way skipped STARVATION_THRESHOLD times is promoted to
// the top level until it is served.
module multi_level_priority_arbiter
    import multi_level_priority_arbiter_pkg::*;
#(
    parameter int NUM_REQUEST                  = 4,
    parameter int SINGLE_REQUEST_WIDTH_IN_BITS = 64,
    parameter int NUM_PRIORITY_LEVEL           = 4,
    parameter int PRIORITY_WIDTH               = 2,
    parameter int STARVATION_THRESHOLD         = 8,
    parameter int AGE_WIDTH                    = 4
) (
    input  logic                                                clk_in,
    input  logic                                                reset_in,
    input  logic [NUM_REQUEST*SINGLE_REQUEST_WIDTH_IN_BITS-1:0] request_flatted_in,
    input  logic [NUM_REQUEST-1:0]                              request_valid_flatted_in,
    input  logic [NUM_REQUEST*PRIORITY_WIDTH-1:0]               request_priority_flatted_in,
    output logic [NUM_REQUEST-1:0]                              issue_ack_out,
    output logic [SINGLE_REQUEST_WIDTH_IN_BITS-1:0]             request_out,
    output logic [$clog2(NUM_REQUEST)-1:0]                      request_way_out,
    output logic                                                request_valid_out,
    input  logic                                                issue_ack_in
);

    localparam int WAY_WIDTH = $clog2(NUM_REQUEST);
    localparam int DW        = SINGLE_REQUEST_WIDTH_IN_BITS;
    localparam logic [PRIORITY_WIDTH-1:0] TOP_PRIO  = PRIORITY_WIDTH'(NUM_PRIORITY_LEVEL - 1);
    localparam logic [AGE_WIDTH-1:0]      AGE_LIMIT = AGE_WIDTH'(STARVATION_THRESHOLD);
    localparam logic [WAY_WIDTH-1:0]      LAST_WAY  = WAY_WIDTH'(NUM_REQUEST - 1);

    arb_state_e                state;
    logic [AGE_WIDTH-1:0]      age [NUM_REQUEST];
    logic [WAY_WIDTH-1:0]      last_grant;
    logic [PRIORITY_WIDTH-1:0] eff_prio [NUM_REQUEST];
    logic [PRIORITY_WIDTH-1:0] max_prio;
    logic [NUM_REQUEST-1:0]    candidate_mask;
    logic [NUM_REQUEST-1:0]    winner_onehot;
    logic [WAY_WIDTH-1:0]      winner_idx;
    logic                      any_valid;

    assign any_valid = |request_valid_flatted_in;

    // Effective priority: starved ways jump to the top level; out-of-range
    // priority inputs are clamped to the top level.
    always_comb begin
        for (int i = 0; i < NUM_REQUEST; i++) begin
            if (age[i] >= AGE_LIMIT) begin
                eff_prio[i] = TOP_PRIO;
            end else if (request_priority_flatted_in[i*PRIORITY_WIDTH +: PRIORITY_WIDTH] > TOP_PRIO) begin
                eff_prio[i] = TOP_PRIO;
            end else begin
                eff_prio[i] = request_priority_flatted_in[i*PRIORITY_WIDTH +: PRIORITY_WIDTH];
            end
        end
    end

    // Highest effective level among the valid ways.
    always_comb begin
        max_prio = '0;
        for (int i = 0; i < NUM_REQUEST; i++) begin
            if (request_valid_flatted_in[i] && (eff_prio[i] > max_prio)) begin
                max_prio = eff_prio[i];
            end
        end
    end

    // Candidates are the valid ways sitting at that highest level.
    always_comb begin
        for (int i = 0; i < NUM_REQUEST; i++) begin
            candidate_mask[i] = request_valid_flatted_in[i] && (eff_prio[i] == max_prio);
        end
    end

    rr_mask_picker #(
        .NUM_REQUEST (NUM_REQUEST),
        .WAY_WIDTH   (WAY_WIDTH)
    ) u_picker (
        .candidate_mask (candidate_mask),
        .last_grant     (last_grant),
        .winner_onehot  (winner_onehot)
    );

    // Encode the one-hot winner into a way index.
    always_comb begin
        winner_idx = '0;
        for (int i = 0; i < NUM_REQUEST; i++) begin
            if (winner_onehot[i]) begin
                winner_idx = WAY_WIDTH'(i);
            end
        end
    end

    // Grant/hold controller with registered outputs and per-way age tracking.
    always_ff @(posedge clk_in) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset_in) begin
            state             <= ST_IDLE;
            issue_ack_out     <= '0;
            request_out       <= '0;
            request_way_out   <= '0;
            request_valid_out <= 1'b0;
            last_grant        <= LAST_WAY;
            // NOTE: the age array is a handful of flops, not a RAM, and it
            // steers arbitration, so it is reset along with the control state.
            for (int i = 0; i < NUM_REQUEST; i++) begin
                age[i] <= '0;
            end
        end else begin
            issue_ack_out <= '0;
            case (state)
                ST_IDLE: begin
                    if (any_valid) begin
                        request_out       <= request_flatted_in[int'(winner_idx)*DW +: DW];
                        request_way_out   <= winner_idx;
                        request_valid_out <= 1'b1;
                        issue_ack_out     <= winner_onehot;
                        last_grant        <= winner_idx;
                        state             <= ST_HOLD;
                        for (int i = 0; i < NUM_REQUEST; i++) begin
                            if (winner_onehot[i] || !request_valid_flatted_in[i]) begin
                                age[i] <= '0;
                            end else if (age[i] != '1) begin
                                age[i] <= age[i] + 1'b1;
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (issue_ack_in) begin
                        request_out       <= '0;
                        request_way_out   <= '0;
                        request_valid_out <= 1'b0;
                        state             <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_level_priority_arbiter.sv
// Self-checking bench for multi_level_priority_arbiter: a cycle model predicts
// each grant, pushes it to a scoreboard, and the DUT output is compared after
// the edge. Directed scenarios cover round-robin, priority, starvation, hold,
// reset-in-hold and idle behaviour.
module tb_multi_level_priority_arbiter;

    localparam int N   = 4;
    localparam int W   = 64;
    localparam int PW  = 2;
    localparam int NPL = 4;
    localparam int TH  = 8;
    localparam int AW  = 4;
    localparam int AGE_MAX = (1 << AW) - 1;

    logic              clk_in = 1'b0;
    logic              reset_in;
    logic [N*W-1:0]    request_flatted_in;
    logic [N-1:0]      request_valid_flatted_in;
    logic [N*PW-1:0]   request_priority_flatted_in;
    logic [N-1:0]      issue_ack_out;
    logic [W-1:0]      request_out;
    logic [1:0]        request_way_out;
    logic              request_valid_out;
    logic              issue_ack_in;

    always #5 clk_in = ~clk_in;

    multi_level_priority_arbiter dut (
        .clk_in                      (clk_in),
        .reset_in                    (reset_in),
        .request_flatted_in          (request_flatted_in),
        .request_valid_flatted_in    (request_valid_flatted_in),
        .request_priority_flatted_in (request_priority_flatted_in),
        .issue_ack_out               (issue_ack_out),
        .request_out                 (request_out),
        .request_way_out             (request_way_out),
        .request_valid_out           (request_valid_out),
        .issue_ack_in                (issue_ack_in)
    );

    // Stimulus state
    logic [N-1:0]  valid;
    logic [PW-1:0] prio [N];
    logic [W-1:0]  pay  [N];
    int            ack_mode;   // 0: never ack, 1: ack in first HOLD cycle, 2: toggle
    logic          ack_tog;

    always_comb begin
        request_flatted_in          = '0;
        request_priority_flatted_in = '0;
        request_valid_flatted_in    = valid;
        for (int j = 0; j < N; j++) begin
            request_flatted_in[j*W +: W]           = pay[j];
            request_priority_flatted_in[j*PW +: PW] = prio[j];
        end
    end

    // Reference model state
    bit          m_hold;
    int          m_age [N];
    int          m_last;
    logic [W-1:0] m_out;
    int          m_way;

    typedef struct {
        int           way;
        logic [W-1:0] data;
    } exp_t;

    exp_t sb [$];
    int   grant_log [$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int eff(input int i);
        int p;
        p = int'(prio[i]);
        if (p > NPL - 1) p = NPL - 1;
        if (m_age[i] >= TH) p = NPL - 1;
        return p;
    endfunction

    // One clock cycle: drive inputs, advance the model, then compare after the edge.
    task automatic cycle(input logic rst);
        exp_t e;
        bit   pushed;
        int   best;
        int   bestlvl;
        int   idx;
        pushed = 1'b0;
        for (int j = 0; j < N; j++) pay[j] = {$urandom, $urandom};
        reset_in = rst;
        ack_tog  = ~ack_tog;
        case (ack_mode)
            1:       issue_ack_in = m_hold;
            2:       issue_ack_in = ack_tog;
            default: issue_ack_in = 1'b0;
        endcase

        if (rst) begin
            m_hold = 1'b0;
            m_out  = '0;
            m_way  = 0;
            m_last = N - 1;
            for (int j = 0; j < N; j++) m_age[j] = 0;
        end else if (!m_hold) begin
            if (|valid) begin
                best    = -1;
                bestlvl = -1;
                for (int k = 1; k <= N; k++) begin
                    idx = (m_last + k) % N;
                    if (valid[idx] && eff(idx) > bestlvl) begin
                        best    = idx;
                        bestlvl = eff(idx);
                    end
                end
                for (int j = 0; j < N; j++) begin
                    if (j == best || !valid[j]) m_age[j] = 0;
                    else if (m_age[j] < AGE_MAX) m_age[j] = m_age[j] + 1;
                end
                m_last = best;
                m_hold = 1'b1;
                m_out  = pay[best];
                m_way  = best;
                e.way  = best;
                e.data = pay[best];
                sb.push_back(e);
                pushed = 1'b1;
            end
        end else if (issue_ack_in) begin
            m_hold = 1'b0;
            m_out  = '0;
            m_way  = 0;
        end

        @(posedge clk_in);
        #1;

        if (pushed) begin
            e = sb.pop_front();
            check("grant_ack_onehot", 64'(issue_ack_out), 64'(1) << e.way);
            check("grant_way", 64'(request_way_out), 64'(e.way));
            check("grant_data", request_out, e.data);
            grant_log.push_back(int'(request_way_out));
        end else begin
            check("no_ack_pulse", 64'(issue_ack_out), 64'd0);
        end
        check("valid_out", 64'(request_valid_out), 64'(m_hold));
        check("data_out", request_out, m_out);
        check("way_out", 64'(request_way_out), 64'(m_way));
    endtask

    task automatic set_all(input logic [N-1:0] v, input int lvl);
        valid = v;
        for (int j = 0; j < N; j++) prio[j] = PW'(lvl);
    endtask

    initial begin
        logic [N-1:0] seen;
        int exp_order [6];
        exp_order = '{0, 1, 2, 3, 0, 1};
        ack_tog      = 1'b0;
        ack_mode     = 0;
        issue_ack_in = 1'b0;
        reset_in     = 1'b1;
        set_all('0, 0);
        for (int j = 0; j < N; j++) pay[j] = '0;

        // Reset state
        cycle(1'b1);
        cycle(1'b1);

        // All ways at level 0, ack in first HOLD cycle: plain round-robin
        grant_log.delete();
        set_all('1, 0);
        ack_mode = 1;
        for (int c = 0; c < 12; c++) cycle(1'b0);
        check("rr_grant_count", 64'(grant_log.size()), 64'd6);
        for (int g = 0; g < 6 && g < grant_log.size(); g++) begin
            check("rr_order", 64'(grant_log[g]), 64'(exp_order[g]));
        end

        // Way 2 at top level wins first, then the rest share round-robin
        cycle(1'b1);
        grant_log.delete();
        set_all('1, 0);
        prio[2] = 2'd3;
        for (int c = 0; c < 8; c++) begin
            cycle(1'b0);
            if (grant_log.size() >= 1) valid[2] = 1'b0;
        end
        check("prio_grant_count", 64'(grant_log.size()), 64'd4);
        if (grant_log.size() >= 4) begin
            check("prio_first_way2", 64'(grant_log[0]), 64'd2);
            seen = '0;
            for (int g = 1; g < 4; g++) seen[grant_log[g]] = 1'b1;
            check("prio_rest_ways", 64'(seen), 64'(4'b1011));
        end

        // Starvation: way 0 at level 3, way 1 at level 0, both always valid
        cycle(1'b1);
        grant_log.delete();
        set_all(4'b0011, 0);
        prio[0] = 2'd3;
        for (int c = 0; c < 40; c++) cycle(1'b0);
        check("starve_grant_count", 64'(grant_log.size()), 64'd20);
        if (grant_log.size() >= 18) begin
            for (int g = 0; g < 8; g++) check("starve_way0_before", 64'(grant_log[g]), 64'd0);
            check("starve_9th_way1", 64'(grant_log[8]), 64'd1);
            for (int g = 9; g < 17; g++) check("starve_way0_after", 64'(grant_log[g]), 64'd0);
            check("starve_18th_way1", 64'(grant_log[17]), 64'd1);
        end

        // Hold for 20 cycles without downstream ack
        cycle(1'b1);
        grant_log.delete();
        set_all('1, 0);
        ack_mode = 0;
        for (int c = 0; c < 21; c++) cycle(1'b0);
        check("hold_single_grant", 64'(grant_log.size()), 64'd1);
        check("hold_valid_high", 64'(request_valid_out), 64'd1);

        // Reset while holding discards the request; next grant goes to way 0
        cycle(1'b1);
        check("reset_in_hold_valid", 64'(request_valid_out), 64'd0);
        grant_log.delete();
        ack_mode = 1;
        for (int c = 0; c < 4; c++) cycle(1'b0);
        if (grant_log.size() >= 1) check("post_reset_way0", 64'(grant_log[0]), 64'd0);
        else check("post_reset_grant_seen", 64'(grant_log.size()), 64'd1);

        // Idle with no valid ways and a toggling ack
        cycle(1'b1);
        grant_log.delete();
        set_all('0, 0);
        ack_mode = 2;
        for (int c = 0; c < 10; c++) cycle(1'b0);
        check("idle_no_grants", 64'(grant_log.size()), 64'd0);

        // Idle ack must not disturb a later grant
        set_all('1, 0);
        ack_mode = 1;
        for (int c = 0; c < 4; c++) cycle(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
